// File: rtl/histogram_esitleyici.sv
// Histogram equalizer: scans a 256-bin histogram, accumulates the CDF
// and streams one equalized LUT entry per bin using a sequential divider.
module histogram_esitleyici #(
    parameter int PIXEL_BIT    = 8,
    parameter int SAYAC_BIT    = 17,
    parameter int PIXEL_SAYISI = 76800
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 baslat_i,
    output logic                 hist_oku_o,
    output logic [PIXEL_BIT-1:0] hist_adres_o,
    input  logic [SAYAC_BIT-1:0] hist_veri_i,
    output logic                 lut_gecerli_o,
    output logic [PIXEL_BIT-1:0] lut_adres_o,
    output logic [PIXEL_BIT-1:0] lut_veri_o,
    output logic                 mesgul_o,
    output logic                 bitti_o
);

    localparam int BOL_BIT = SAYAC_BIT + PIXEL_BIT;
    localparam int K_BIT = (PIXEL_BIT > 1) ? $clog2(PIXEL_BIT) : 1;
    localparam logic [SAYAC_BIT-1:0] N = SAYAC_BIT'(PIXEL_SAYISI);
    localparam logic [BOL_BIT-1:0] CARPAN = BOL_BIT'((1 << PIXEL_BIT) - 1);
    localparam logic [PIXEL_BIT-1:0] V_SON = '1;
    localparam logic [K_BIT-1:0] K_ILK = K_BIT'(PIXEL_BIT - 1);

    typedef enum logic [2:0] {
        BOSTA, OKU, BEKLE, TOPLA, BOL, YAZ, BITTI
    } durum_t;

    durum_t durum_q, durum_d;

    logic [PIXEL_BIT-1:0] v_q, v_d;
    logic [SAYAC_BIT-1:0] h_q, h_d;
    logic [SAYAC_BIT-1:0] cdf_q, cdf_d;
    logic [SAYAC_BIT-1:0] cdf_min_q, cdf_min_d;
    logic                 min_bulundu_q, min_bulundu_d;
    logic [BOL_BIT-1:0]   kalan_q, kalan_d;
    logic [SAYAC_BIT-1:0] payda_q, payda_d;
    logic [PIXEL_BIT-1:0] bolum_q, bolum_d;
    logic [K_BIT-1:0]     k_q, k_d;
    logic                 sifir_q, sifir_d;
    logic [PIXEL_BIT-1:0] lut_adres_q, lut_adres_d;
    logic [PIXEL_BIT-1:0] lut_veri_q, lut_veri_d;

    logic [SAYAC_BIT:0]   toplam;
    logic [SAYAC_BIT-1:0] cdf_yeni;
    logic [SAYAC_BIT-1:0] cdf_min_yeni;
    logic [SAYAC_BIT-1:0] fark;
    logic [SAYAC_BIT-1:0] payda_yeni;
    logic [BOL_BIT-1:0]   bolen;
    logic                 ilk_min;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            BOSTA:   if (baslat_i) durum_d = OKU;
            OKU:     durum_d = BEKLE;
            BEKLE:   durum_d = TOPLA;
            TOPLA:   durum_d = BOL;
            BOL:     if (k_q == '0) durum_d = YAZ;
            YAZ:     durum_d = (v_q == V_SON) ? BITTI : OKU;
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    always_comb begin
        hist_oku_o    = (durum_q == OKU);
        lut_gecerli_o = (durum_q == YAZ);
        mesgul_o      = (durum_q != BOSTA);
        bitti_o       = (durum_q == BITTI);
        hist_adres_o  = v_q;
        lut_adres_o   = lut_adres_q;
        lut_veri_o    = lut_veri_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v_q           <= '0;
            h_q           <= '0;
            cdf_q         <= '0;
            cdf_min_q     <= '0;
            min_bulundu_q <= 1'b0;
            kalan_q       <= '0;
            payda_q       <= '0;
            bolum_q       <= '0;
            k_q           <= '0;
            sifir_q       <= 1'b0;
            lut_adres_q   <= '0;
            lut_veri_q    <= '0;
        end else begin
            v_q           <= v_d;
            h_q           <= h_d;
            cdf_q         <= cdf_d;
            cdf_min_q     <= cdf_min_d;
            min_bulundu_q <= min_bulundu_d;
            kalan_q       <= kalan_d;
            payda_q       <= payda_d;
            bolum_q       <= bolum_d;
            k_q           <= k_d;
            sifir_q       <= sifir_d;
            lut_adres_q   <= lut_adres_d;
            lut_veri_q    <= lut_veri_d;
        end
    end

    // A first bin larger than N would make cdf < cdf_min; clamp to zero.
    always_comb begin
        toplam       = {1'b0, cdf_q} + {1'b0, h_q};
        cdf_yeni     = (toplam > {1'b0, N}) ? N : toplam[SAYAC_BIT-1:0];
        ilk_min      = !min_bulundu_q && (h_q != '0);
        cdf_min_yeni = ilk_min ? h_q : cdf_min_q;
        fark         = (cdf_yeni > cdf_min_yeni) ? cdf_yeni - cdf_min_yeni : '0;
        payda_yeni   = (N > cdf_min_yeni) ? N - cdf_min_yeni : '0;
        bolen        = BOL_BIT'(payda_q) << k_q;

        v_d           = v_q;
        h_d           = h_q;
        cdf_d         = cdf_q;
        cdf_min_d     = cdf_min_q;
        min_bulundu_d = min_bulundu_q;
        kalan_d       = kalan_q;
        payda_d       = payda_q;
        bolum_d       = bolum_q;
        k_d           = k_q;
        sifir_d       = sifir_q;
        lut_adres_d   = lut_adres_q;
        lut_veri_d    = lut_veri_q;

        unique case (durum_q)
            BOSTA: begin
                if (baslat_i) begin
                    v_d           = '0;
                    cdf_d         = '0;
                    cdf_min_d     = '0;
                    min_bulundu_d = 1'b0;
                end
            end
            BEKLE: h_d = hist_veri_i;
            TOPLA: begin
                cdf_d         = cdf_yeni;
                cdf_min_d     = cdf_min_yeni;
                min_bulundu_d = min_bulundu_q | ilk_min;
                kalan_d       = BOL_BIT'(fark) * CARPAN;
                payda_d       = payda_yeni;
                bolum_d       = '0;
                k_d           = K_ILK;
                sifir_d       = (cdf_yeni == '0) || (payda_yeni == '0);
            end
            BOL: begin
                if (kalan_q >= bolen) begin
                    kalan_d      = kalan_q - bolen;
                    bolum_d[k_q] = 1'b1;
                end
                k_d = k_q - 1'b1;
                if (k_q == '0) begin
                    lut_adres_d = v_q;
                    lut_veri_d  = sifir_q ? '0 : bolum_d;
                end
            end
            YAZ: begin
                if (v_q != V_SON) v_d = v_q + 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_histogram_esitleyici.sv
// Bench for histogram_esitleyici: BRAM model, behavioural LUT model,
// per-cycle cadence and data comparison.
module tb_histogram_esitleyici;

    localparam int BIN = 256;
    localparam int NP  = 76800;

    logic        clk = 1'b0;
    logic        rstn;
    logic        baslat;
    logic        hist_oku;
    logic [7:0]  hist_adres;
    logic [16:0] hist_veri = '0;
    logic        lut_g;
    logic [7:0]  lut_adres;
    logic [7:0]  lut_veri;
    logic        mesgul;
    logic        bitti;
    logic [27:0] tum;

    histogram_esitleyici dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .baslat_i     (baslat),
        .hist_oku_o   (hist_oku),
        .hist_adres_o (hist_adres),
        .hist_veri_i  (hist_veri),
        .lut_gecerli_o(lut_g),
        .lut_adres_o  (lut_adres),
        .lut_veri_o   (lut_veri),
        .mesgul_o     (mesgul),
        .bitti_o      (bitti)
    );

    always #5 clk = ~clk;

    assign tum = {hist_oku, hist_adres, lut_g, lut_adres,
                  lut_veri, mesgul, bitti};

    logic [16:0] mem [BIN];
    int beklenen [BIN];

    always @(posedge clk) if (hist_oku) hist_veri <= mem[hist_adres];

    int gecen = 0;
    int toplam = 0;
    int cyc = 0;
    bit izle = 0;
    bit tutuldu = 0;
    int darbe = 0;
    int bit_say = 0;

    task automatic kontrol(input string ad, input longint g, input longint b);
        toplam++;
        if (g == b) gecen++;
        else $display("FAIL %s: got %0d expected %0d", ad, g, b);
    endtask

    function automatic void model();
        longint cdf = 0;
        longint mn = 0;
        bit bul = 0;
        for (int v = 0; v < BIN; v++) begin
            cdf = cdf + longint'(mem[v]);
            if (cdf > NP) cdf = NP;
            if (!bul && mem[v] != 0) begin
                mn  = longint'(mem[v]);
                bul = 1;
            end
            if (cdf == 0 || mn >= NP) beklenen[v] = 0;
            else beklenen[v] = int'((cdf - mn) * 255 / (NP - mn));
        end
    endfunction

    int e;
    bit eo, el, em, eb;
    always @(negedge clk) begin
        if (izle) begin
            e = cyc;
            if (tutuldu && cyc >= 3074) e = cyc - 3074;
            eo = e >= 1 && e <= 3061 && (e - 1) % 12 == 0;
            el = e >= 12 && e <= 3072 && (e - 12) % 12 == 0;
            em = e >= 1 && e <= 3073;
            eb = e == 3073;
            kontrol($sformatf("cadence@%0d", cyc),
                    {hist_oku, lut_g, mesgul, bitti}, {eo, el, em, eb});
            if (eo)
                kontrol($sformatf("hist_adres@%0d", cyc),
                        hist_adres, (e - 1) / 12);
            if (el) begin
                kontrol($sformatf("lut_adres@%0d", cyc),
                        lut_adres, (e - 12) / 12);
                kontrol($sformatf("lut_veri[%0d]", (e - 12) / 12),
                        lut_veri, beklenen[(e - 12) / 12]);
            end
            if (lut_g) darbe++;
            if (bitti) bit_say++;
            cyc++;
        end
    end

    task automatic temizle();
        for (int v = 0; v < BIN; v++) mem[v] = '0;
    endtask

    task automatic birim();
        for (int v = 0; v < BIN; v++) mem[v] = 17'd300;
    endtask

    task automatic rastgele(input int lo);
        int b;
        temizle();
        repeat (400) begin
            b = $urandom_range(lo, 255);
            mem[b] = mem[b] + 17'd192;
        end
    endtask

    task automatic calistir(input bit tut);
        model();
        darbe = 0;
        bit_say = 0;
        @(posedge clk);
        #2;
        baslat = 1'b1;
        cyc = 0;
        tutuldu = tut;
        izle = 1'b1;
        if (!tut) begin
            @(posedge clk);
            #2;
            baslat = 1'b0;
            repeat (3074) @(posedge clk);
        end else begin
            repeat (3076) @(posedge clk);
        end
        #2;
        izle = 1'b0;
        baslat = 1'b0;
        kontrol("lut_pulses", darbe, 256);
        kontrol("bitti_pulses", bit_say, 1);
    endtask

    int n;
    initial begin
        rstn = 1'b0;
        baslat = 1'b0;
        temizle();
        #1;
        kontrol("reset_outputs", tum, 0);
        #20;
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        kontrol("idle_outputs", tum, 0);

        birim();
        model();
        kontrol("model_uniform[37]", beklenen[37], 37);
        kontrol("model_uniform[255]", beklenen[255], 255);
        calistir(0);

        temizle();
        mem[10] = 17'd38400;
        mem[200] = 17'd38400;
        model();
        kontrol("model_two[199]", beklenen[199], 0);
        kontrol("model_two[200]", beklenen[200], 255);
        calistir(0);

        temizle();
        mem[128] = 17'(NP);
        model();
        kontrol("model_single[128]", beklenen[128], 0);
        calistir(0);

        temizle();
        mem[0] = 17'd100;
        mem[255] = 17'(NP);
        model();
        kontrol("model_sat[254]", beklenen[254], 0);
        kontrol("model_sat[255]", beklenen[255], 255);
        calistir(0);

        rastgele(0);
        calistir(0);
        rastgele($urandom_range(1, 60));
        calistir(0);

        temizle();
        for (int v = $urandom_range(0, 20); v < BIN; v++)
            mem[v] = 17'($urandom_range(0, 1000));
        calistir(0);

        rastgele($urandom_range(0, 30));
        calistir(1);
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;

        birim();
        model();
        darbe = 0;
        bit_say = 0;
        @(posedge clk);
        #2;
        baslat = 1'b1;
        cyc = 0;
        tutuldu = 1'b0;
        izle = 1'b1;
        @(posedge clk);
        #2;
        baslat = 1'b0;
        repeat (1205) @(posedge clk);
        #2;
        izle = 1'b0;
        #1;
        kontrol("midrun_busy", mesgul, 1);
        kontrol("midrun_pulses", darbe, 100);
        rstn = 1'b0;
        #1;
        kontrol("midrun_reset_outputs", tum, 0);
        repeat (2) @(posedge clk);
        #1;
        kontrol("midrun_reset_hold", tum, 0);
        #1;
        rstn = 1'b1;
        n = 0;
        repeat (3100) begin
            @(negedge clk);
            if (mesgul || bitti || hist_oku || lut_g) n++;
        end
        kontrol("after_reset_idle", n, 0);
        calistir(0);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
